// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage.
// It handles signed (DIV) and unsigned (DIVU) division. The result is
// {remainder, quotient}, and the remainder takes the sign of the dividend.
// The engine works on magnitudes and applies the sign fix on the last
// iteration. Every output is a register.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     op1_i,
    input  logic [DATA_W-1:0]     op2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sgn_q;      // latched signed_i
    logic                  neg1_q;     // dividend was negative
    logic                  neg2_q;     // divisor was negative
    logic [DATA_W-1:0]     d_q;        // |divisor|
    logic [DATA_W-1:0]     q_q;        // shifting dividend / quotient
    logic [DATA_W:0]       r_q;        // partial remainder

    logic [DATA_W:0]       shift_r;
    logic signed [DATA_W:0] trial;
    logic [DATA_W:0]       r_nx;
    logic [DATA_W-1:0]     q_nx;
    logic [CNT_W-1:0]      cnt_nx;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    // Two's complement negation; wraps 0x80..0 onto itself.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
        return (~x) + DATA_W'(1);
    endfunction

    // Magnitude of an operand: negated only when signed and negative.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                  input logic              sgn);
        return (sgn && x[DATA_W-1]) ? negate(x) : x;
    endfunction

    // One restoring iteration plus the sign-corrected result of that iteration.
    always_comb begin
        shift_r = {r_q[DATA_W-1:0], q_q[DATA_W-1]};
        trial   = $signed(shift_r) - $signed({1'b0, d_q});
        if (!trial[DATA_W]) begin
            r_nx = trial;
            q_nx = {q_q[DATA_W-2:0], 1'b1};
        end else begin
            r_nx = shift_r;
            q_nx = {q_q[DATA_W-2:0], 1'b0};
        end
        cnt_nx  = cnt_q + CNT_W'(1);
        quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? negate(q_nx) : q_nx;
        rem_fix = (sgn_q && neg1_q) ? negate(r_nx[DATA_W-1:0]) : r_nx[DATA_W-1:0];
    end

    // Sequencing FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            d_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        sgn_q  <= signed_i;
                        neg1_q <= op1_i[DATA_W-1];
                        neg2_q <= op2_i[DATA_W-1];
                        busy_o <= 1'b1;
                        if (op2_i == '0) begin
                            state_q <= BYZERO;
                        end else begin
                            d_q     <= abs_val(op2_i, signed_i);
                            q_q     <= abs_val(op1_i, signed_i);
                            r_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                BYZERO: begin
                    busy_o <= 1'b0;
                    if (annul_i) begin
                        state_q <= IDLE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                RUN: begin
                    if (annul_i) begin
                        cnt_q   <= '0;
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        r_q   <= r_nx;
                        q_q   <= q_nx;
                        cnt_q <= cnt_nx;
                        if (cnt_nx == LAST_CNT) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: table vectors, hand-written corner sequences,
// and random operations compared with an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .signed_i (signed_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .start_i  (start_i),
        .annul_i  (annul_i),
        .result_o (result_o),
        .ready_o  (ready_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: truncating division written with plain integer arithmetic.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int sq;
        int sr;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = int'(a);
        sb = int'(b);
        sq = sa / sb;
        sr = sa % sb;
        return {32'(sr), 32'(sq)};
    endfunction

    // Raise start and wait for ready. cyc counts the rising edges from raising start to ready.
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int cyc);
        @(negedge clk);
        signed_i = s;
        op1_i    = a;
        op2_i    = b;
        start_i  = 1'b1;
        cyc      = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_after_accept", {63'd0, busy_o}, 64'd1);
                op1_i    = $urandom;
                op2_i    = $urandom;
                signed_i = ~s;
            end
            if (ready_o) break;
        end
        if (!ready_o) begin
            check("ready_timeout", {63'd0, ready_o}, 64'd1);
        end
        res = result_o;
    endtask

    // Drop start and check that DONE returns to IDLE with cleared outputs.
    task automatic release_op();
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_ready", {63'd0, ready_o}, 64'd0);
        check("release_result", result_o, 64'd0);
        check("release_busy", {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        int          cyc;
        int          seen;
        bit          rs;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
        tbl[3] = '{1'b0, 32'h0000_1234,  32'd0,        32'd0,         32'd0};
        tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
        tbl[6] = '{1'b0, 32'd9,          32'd3,        32'd3,         32'd0};
        tbl[7] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE};
        tbl[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};

        rst      = 1'b0;
        signed_i = 1'b0;
        op1_i    = '0;
        op2_i    = '0;
        start_i  = 1'b0;
        annul_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result_o, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        rst = 1'b1;

        // Table vectors with the result and the latency of each.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, res, cyc);
            check($sformatf("tbl%0d_result", i), res, {tbl[i].r, tbl[i].q});
            check($sformatf("tbl%0d_latency", i), 64'(cyc), (tbl[i].b == 0) ? 64'd2 : 64'd33);
            release_op();
        end

        // Annul on RUN cycle 10: back to IDLE and no result.
        @(negedge clk);
        signed_i = 1'b0;
        op1_i    = 32'h1234_5678;
        op2_i    = 32'd3;
        start_i  = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_busy", {63'd0, busy_o}, 64'd0);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, res, cyc);
        check("post_annul_result", res, {32'd0, 32'hFFFF_FFFF});
        check("post_annul_latency", 64'(cyc), 64'd33);
        release_op();

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge clk);
        signed_i = 1'b0;
        op1_i    = 32'd1000;
        op2_i    = 32'd10;
        start_i  = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy_o}, 64'd0);
        check("async_rst_ready", {63'd0, ready_o}, 64'd0);
        check("async_rst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("async_rst_no_result", 64'(seen), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, res, cyc);
        check("post_rst_result", res, {32'd0, 32'd3});
        release_op();

        // Asynchronous reset in DONE clears the held result.
        run_op(1'b0, 32'd100, 32'd7, res, cyc);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("done_rst_result", result_o, 64'd0);
        check("done_rst_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Overflow case with start held past ready. annul is ignored in DONE.
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc);
        check("ovf_result", res, {32'd0, 32'h8000_0000});
        held = res;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) annul_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            annul_i = 1'b0;
            check($sformatf("hold%0d_result", k), result_o, held);
            check($sformatf("hold%0d_ready", k), {63'd0, ready_o}, 64'd1);
        end
        release_op();

        // Random operations compared with the reference model.
        for (int n = 0; n < 60; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(rs, ra, rb, res, cyc);
            check($sformatf("rand%0d_s%0d_%h_%h", n, rs, ra, rb), res, model(rs, ra, rb));
            release_op();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
